// File: rtl/bus_sequencer_pkg.sv
// rtl/bus_sequencer_pkg.sv - shared constants and types for the bus sequencer
package bus_sequencer_pkg;

    // Instruction classes (ir[7:4] when ir[7] = 0)
    localparam logic [3:0] CLS_LOAD  = 4'b0000;
    localparam logic [3:0] CLS_STORE = 4'b0001;
    localparam logic [3:0] CLS_DATA  = 4'b0010;
    localparam logic [3:0] CLS_JMPR  = 4'b0011;
    localparam logic [3:0] CLS_JMP   = 4'b0100;
    localparam logic [3:0] CLS_JMPIF = 4'b0101;
    localparam logic [3:0] CLS_CLF   = 4'b0110;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SHR = 3'b001;
    localparam logic [2:0] ALU_SHL = 3'b010;
    localparam logic [2:0] ALU_NOT = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;
    localparam logic [2:0] ALU_CMP = 3'b111;

    localparam int FLAG_C = 3;
    localparam int FLAG_A = 2;
    localparam int FLAG_E = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [6:0] {
        STEP1 = 7'b0000001,
        STEP2 = 7'b0000010,
        STEP3 = 7'b0000100,
        STEP4 = 7'b0001000,
        STEP5 = 7'b0010000,
        STEP6 = 7'b0100000,
        STEP7 = 7'b1000000
    } step_e;

    function automatic logic [3:0] sel_reg(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/bus_sequencer_if.sv
// rtl/bus_sequencer_if.sv - instruction inputs and control strobe outputs of the sequencer
interface bus_sequencer_if;
    logic       run;
    logic [7:0] ir;
    logic [3:0] flags;
    logic [6:0] step;
    logic [3:0] reg_en;
    logic [3:0] reg_set;
    logic       tmp_set;
    logic       acc_set;
    logic       acc_en;
    logic       iar_set;
    logic       iar_en;
    logic       mar_set;
    logic       ram_set;
    logic       ram_en;
    logic       ir_set;
    logic       flags_set;
    logic       bus1;
    logic [2:0] alu_op;

    modport slave (
        input  run, ir, flags,
        output step, reg_en, reg_set, tmp_set, acc_set, acc_en, iar_set, iar_en,
               mar_set, ram_set, ram_en, ir_set, flags_set, bus1, alu_op
    );

    modport master (
        output run, ir, flags,
        input  step, reg_en, reg_set, tmp_set, acc_set, acc_en, iar_set, iar_en,
               mar_set, ram_set, ram_en, ir_set, flags_set, bus1, alu_op
    );
endinterface

// File: rtl/bus_sequencer_stepper.sv
// rtl/bus_sequencer_stepper.sv - one-hot seven-step counter with run hold and reset
module bus_sequencer_stepper
    import bus_sequencer_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  i_run,
    output step_e o_step
);

    step_e r_step;
    step_e w_step_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_step <= STEP1;
        end else begin
            r_step <= w_step_next;
        end
    end

    always_comb begin
        w_step_next = r_step;
        if (i_run) begin
            case (r_step)
                STEP1:   w_step_next = STEP2;
                STEP2:   w_step_next = STEP3;
                STEP3:   w_step_next = STEP4;
                STEP4:   w_step_next = STEP5;
                STEP5:   w_step_next = STEP6;
                STEP6:   w_step_next = STEP7;
                STEP7:   w_step_next = STEP1;
                default: w_step_next = STEP1;
            endcase
        end
    end

    assign o_step = r_step;

endmodule

// File: rtl/bus_sequencer.sv
// rtl/bus_sequencer.sv - control sequencer: stepper plus combinational strobe decode per step and instruction
module bus_sequencer
    import bus_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    bus_sequencer_if.slave   bus
);

    step_e      w_step;
    logic [3:0] w_class;
    logic [3:0] w_ra_sel;
    logic [3:0] w_rb_sel;
    logic       w_jump_taken;

    logic [3:0] w_reg_en;
    logic [3:0] w_reg_set;
    logic       w_tmp_set, w_acc_set, w_acc_en, w_iar_set, w_iar_en;
    logic       w_mar_set, w_ram_set, w_ram_en, w_ir_set, w_flags_set, w_bus1;
    logic [2:0] w_alu_op;

    bus_sequencer_stepper u_stepper (
        .clk    (clk),
        .reset  (reset),
        .i_run  (bus.run),
        .o_step (w_step)
    );

    assign w_class      = bus.ir[7:4];
    assign w_ra_sel     = sel_reg(bus.ir[3:2]);
    assign w_rb_sel     = sel_reg(bus.ir[1:0]);
    assign w_jump_taken = |(bus.ir[3:0] & bus.flags);

    always_comb begin
        w_reg_en    = '0;
        w_reg_set   = '0;
        w_tmp_set   = 1'b0;
        w_acc_set   = 1'b0;
        w_acc_en    = 1'b0;
        w_iar_set   = 1'b0;
        w_iar_en    = 1'b0;
        w_mar_set   = 1'b0;
        w_ram_set   = 1'b0;
        w_ram_en    = 1'b0;
        w_ir_set    = 1'b0;
        w_flags_set = 1'b0;
        w_bus1      = 1'b0;
        w_alu_op    = ALU_ADD;
        if (!reset) begin
            case (w_step)
                // Fetch: IAR -> MAR, IAR+1 -> ACC, RAM -> IR, ACC -> IAR
                STEP1: begin
                    w_bus1 = 1'b1; w_iar_en = 1'b1; w_mar_set = 1'b1; w_acc_set = 1'b1;
                end
                STEP2: begin
                    w_ram_en = 1'b1; w_ir_set = 1'b1;
                end
                STEP3: begin
                    w_acc_en = 1'b1; w_iar_set = 1'b1;
                end
                STEP4: begin
                    if (bus.ir[7]) begin
                        w_reg_en = w_rb_sel; w_tmp_set = 1'b1;
                    end else begin
                        case (w_class)
                            CLS_LOAD, CLS_STORE: begin
                                w_reg_en = w_ra_sel; w_mar_set = 1'b1;
                            end
                            CLS_DATA, CLS_JMPIF: begin
                                w_bus1 = 1'b1; w_iar_en = 1'b1; w_mar_set = 1'b1; w_acc_set = 1'b1;
                            end
                            CLS_JMPR: begin
                                w_reg_en = w_rb_sel; w_iar_set = 1'b1;
                            end
                            CLS_JMP: begin
                                w_iar_en = 1'b1; w_mar_set = 1'b1;
                            end
                            CLS_CLF: begin
                                w_bus1 = 1'b1; w_flags_set = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                STEP5: begin
                    if (bus.ir[7]) begin
                        w_reg_en = w_ra_sel; w_alu_op = bus.ir[6:4];
                        w_acc_set = 1'b1; w_flags_set = 1'b1;
                    end else begin
                        case (w_class)
                            CLS_LOAD, CLS_DATA: begin
                                w_ram_en = 1'b1; w_reg_set = w_rb_sel;
                            end
                            CLS_STORE: begin
                                w_reg_en = w_rb_sel; w_ram_set = 1'b1;
                            end
                            CLS_JMP: begin
                                w_ram_en = 1'b1; w_iar_set = 1'b1;
                            end
                            CLS_JMPIF: begin
                                w_acc_en = 1'b1; w_iar_set = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                STEP6: begin
                    // CMP only updates flags, so its result is never written back
                    if (bus.ir[7]) begin
                        if (bus.ir[6:4] != ALU_CMP) begin
                            w_acc_en = 1'b1; w_reg_set = w_rb_sel;
                        end
                    end else begin
                        case (w_class)
                            CLS_DATA: begin
                                w_acc_en = 1'b1; w_iar_set = 1'b1;
                            end
                            CLS_JMPIF: begin
                                if (w_jump_taken) begin
                                    w_ram_en = 1'b1; w_iar_set = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.step      = w_step;
    assign bus.reg_en    = w_reg_en;
    assign bus.reg_set   = w_reg_set;
    assign bus.tmp_set   = w_tmp_set;
    assign bus.acc_set   = w_acc_set;
    assign bus.acc_en    = w_acc_en;
    assign bus.iar_set   = w_iar_set;
    assign bus.iar_en    = w_iar_en;
    assign bus.mar_set   = w_mar_set;
    assign bus.ram_set   = w_ram_set;
    assign bus.ram_en    = w_ram_en;
    assign bus.ir_set    = w_ir_set;
    assign bus.flags_set = w_flags_set;
    assign bus.bus1      = w_bus1;
    assign bus.alu_op    = w_alu_op;

endmodule

// File: tb/tb_bus_sequencer.sv
// tb/tb_bus_sequencer.sv - self-checking bench for bus_sequencer
module tb_bus_sequencer;

    typedef struct packed {
        logic [3:0] reg_en;
        logic [3:0] reg_set;
        logic       tmp_set, acc_set, acc_en, iar_set, iar_en;
        logic       mar_set, ram_set, ram_en, ir_set, flags_set, bus1;
        logic [2:0] alu_op;
    } strb_t;

    logic clk = 1'b0;
    logic reset;
    logic chk_en = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   m_step = 1;
    strb_t act;
    strb_t e;

    bus_sequencer_if bif();

    bus_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    assign act = {bif.reg_en, bif.reg_set, bif.tmp_set, bif.acc_set, bif.acc_en, bif.iar_set,
                  bif.iar_en, bif.mar_set, bif.ram_set, bif.ram_en, bif.ir_set, bif.flags_set,
                  bif.bus1, bif.alu_op};

    // Whole-instruction micro-program: the seven step records, indexed by step number
    function automatic strb_t model(input int s, input logic [7:0] ir_v, input logic [3:0] fl,
                                    input logic rst);
        strb_t seq[7];
        strb_t incr;
        strb_t acc2iar;
        logic [3:0] ra1;
        logic [3:0] rb1;
        logic [3:0] one;
        one = 4'b0001;
        ra1 = one << ir_v[3:2];
        rb1 = one << ir_v[1:0];
        incr = '0;
        incr.bus1 = 1'b1; incr.iar_en = 1'b1; incr.mar_set = 1'b1; incr.acc_set = 1'b1;
        acc2iar = '0;
        acc2iar.acc_en = 1'b1; acc2iar.iar_set = 1'b1;
        for (int i = 0; i < 7; i++) seq[i] = '0;
        seq[0] = incr;
        seq[1].ram_en = 1'b1; seq[1].ir_set = 1'b1;
        seq[2] = acc2iar;
        if (ir_v[7]) begin
            seq[3].reg_en = rb1; seq[3].tmp_set = 1'b1;
            seq[4].reg_en = ra1; seq[4].alu_op = ir_v[6:4];
            seq[4].acc_set = 1'b1; seq[4].flags_set = 1'b1;
            if (ir_v[6:4] != 3'd7) begin
                seq[5].acc_en = 1'b1; seq[5].reg_set = rb1;
            end
        end else begin
            case (ir_v[6:4])
                3'd0: begin
                    seq[3].reg_en = ra1; seq[3].mar_set = 1'b1;
                    seq[4].ram_en = 1'b1; seq[4].reg_set = rb1;
                end
                3'd1: begin
                    seq[3].reg_en = ra1; seq[3].mar_set = 1'b1;
                    seq[4].reg_en = rb1; seq[4].ram_set = 1'b1;
                end
                3'd2: begin
                    seq[3] = incr;
                    seq[4].ram_en = 1'b1; seq[4].reg_set = rb1;
                    seq[5] = acc2iar;
                end
                3'd3: begin
                    seq[3].reg_en = rb1; seq[3].iar_set = 1'b1;
                end
                3'd4: begin
                    seq[3].iar_en = 1'b1; seq[3].mar_set = 1'b1;
                    seq[4].ram_en = 1'b1; seq[4].iar_set = 1'b1;
                end
                3'd5: begin
                    seq[3] = incr;
                    seq[4] = acc2iar;
                    if ((ir_v[3:0] & fl) != 4'd0) begin
                        seq[5].ram_en = 1'b1; seq[5].iar_set = 1'b1;
                    end
                end
                3'd6: begin
                    seq[3].bus1 = 1'b1; seq[3].flags_set = 1'b1;
                end
                default: ;
            endcase
        end
        if (rst || s < 1 || s > 7) return '0;
        return seq[s-1];
    endfunction

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] x);
        n_tests++;
        if (a !== x) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, a, x);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (reset) m_step <= 1;
        else if (bif.run) m_step <= (m_step == 7) ? 1 : m_step + 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("step", 32'(bif.step), 32'(7'd1 << (m_step - 1)));
            chk("strobes", 32'(act), 32'(model(m_step, bif.ir, bif.flags, reset)));
            chk("one_enable",
                32'($countones({bif.reg_en, bif.acc_en, bif.iar_en, bif.ram_en}) <= 1), 32'd1);
        end
    end

    initial begin
        logic [6:0] seq_exp [8];
        seq_exp = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h01};
        reset = 1'b1; bif.run = 1'b1; bif.ir = 8'h00; bif.flags = 4'h0;
        adv(1);
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_step", 32'(bif.step), 32'h01);
        chk("reset_strobes", 32'(act), 32'h0);
        adv(1);
        reset = 1'b0;
        @(negedge clk);
        e = '0; e.bus1 = 1'b1; e.iar_en = 1'b1; e.mar_set = 1'b1; e.acc_set = 1'b1;
        chk("fetch1", 32'(act), 32'(e));
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                adv(1);
                @(negedge clk);
            end
            chk("step_seq", 32'(bif.step), 32'(seq_exp[i]));
        end

        adv(1); bif.ir = 8'b1000_0110;
        adv(2); @(negedge clk);
        e = '0; e.reg_en = 4'b0100; e.tmp_set = 1'b1;
        chk("add_s4", 32'(act), 32'(e));
        adv(1); @(negedge clk);
        e = '0; e.reg_en = 4'b0010; e.acc_set = 1'b1; e.flags_set = 1'b1;
        chk("add_s5", 32'(act), 32'(e));
        adv(1); @(negedge clk);
        e = '0; e.acc_en = 1'b1; e.reg_set = 4'b0100;
        chk("add_s6", 32'(act), 32'(e));

        adv(2);
        adv(1); bif.ir = 8'b1111_0001;
        adv(3); @(negedge clk);
        chk("cmp_alu_op", 32'(bif.alu_op), 32'd7);
        chk("cmp_flags_set", 32'(bif.flags_set), 32'd1);
        adv(1); @(negedge clk);
        chk("cmp_s6_idle", 32'(act), 32'h0);

        adv(2);
        adv(1); bif.ir = 8'h52; bif.flags = 4'b0010;
        adv(4); @(negedge clk);
        e = '0; e.ram_en = 1'b1; e.iar_set = 1'b1;
        chk("jmpif_taken", 32'(act), 32'(e));
        adv(2);
        adv(1); bif.flags = 4'b0101;
        adv(4); @(negedge clk);
        chk("jmpif_not_taken", 32'(act), 32'h0);

        adv(4);
        bif.run = 1'b0;
        e = '0; e.acc_en = 1'b1; e.iar_set = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) adv(1);
            @(negedge clk);
            chk("hold_step", 32'(bif.step), 32'h04);
            chk("hold_strobes", 32'(act), 32'(e));
        end
        #1 bif.run = 1'b1;
        adv(1); @(negedge clk);
        chk("resume_step", 32'(bif.step), 32'h08);

        #1 bif.ir = 8'h1B;
        adv(1); reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_step", 32'(bif.step), 32'h10);
        chk("rst_mid_strobes", 32'(act), 32'h0);
        adv(1); reset = 1'b0;
        @(negedge clk);
        chk("rst_after_step", 32'(bif.step), 32'h01);
        e = '0; e.bus1 = 1'b1; e.iar_en = 1'b1; e.mar_set = 1'b1; e.acc_set = 1'b1;
        chk("rst_after_fetch", 32'(act), 32'(e));

        for (int i = 0; i < 3000; i++) begin
            adv(1);
            bif.run   = ($urandom_range(0, 9) != 0);
            reset     = ($urandom_range(0, 63) == 0);
            bif.ir    = 8'($urandom);
            bif.flags = 4'($urandom);
        end
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
